// File: rtl/mem_pkg.sv
// Shared types for the memory reservation station: data/tag widths, the queue
// entry layout and the CDB tag-match helper.
package mem_pkg;

  localparam int TAG_W  = 3;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic              rdy;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] value;
  } mem_opnd_t;

  typedef struct packed {
    logic             valid;
    logic             mem_read;
    logic             mem_write;
    logic [TAG_W-1:0] id;
    mem_opnd_t        a;
    mem_opnd_t        b;
    mem_opnd_t        d;
  } mem_entry_t;

  // An operand wants the broadcast only while it is still waiting on that producer.
  function automatic logic cdb_hit(input logic             rdy,
                                   input logic [TAG_W-1:0] tag,
                                   input logic             cdb_valid,
                                   input logic [TAG_W-1:0] cdb_id);
    return cdb_valid && !rdy && (tag == cdb_id);
  endfunction

endpackage

// File: rtl/mem_rs_operand.sv
// One queued operand: snoops the CDB and captures the broadcast value when the
// producer tag matches. Purely combinational; the owning queue registers it.
module mem_rs_operand
  import mem_pkg::*;
(
  input  logic              valid_i,
  input  mem_opnd_t         opnd_i,
  input  logic              cdb_valid_i,
  input  logic [TAG_W-1:0]  cdb_id_i,
  input  logic [DATA_W-1:0] cdb_value_i,
  output mem_opnd_t         opnd_o
);

  always_comb begin
    opnd_o = opnd_i;
    if (valid_i && cdb_hit(opnd_i.rdy, opnd_i.tag, cdb_valid_i, cdb_id_i)) begin
      opnd_o.rdy   = 1'b1;
      opnd_o.value = cdb_value_i;
    end
  end

endmodule

// File: rtl/mem_rs.sv
// In-order memory reservation station: circular queue, head-only issue into the
// memory pipe. Macro MEM_RS_CDB_BYPASS_EN lets a dispatching operand catch the CDB.
module mem_rs #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             disp_valid,
  input  logic             disp_MemRead,
  input  logic             disp_MemWrite,
  input  logic [TAG_W-1:0] disp_id,
  output logic             disp_ready,
  input  logic             disp_A_rdy,
  input  logic [TAG_W-1:0] disp_A_tag,
  input  logic [31:0]      disp_A_value,
  input  logic             disp_B_rdy,
  input  logic [TAG_W-1:0] disp_B_tag,
  input  logic [31:0]      disp_B_value,
  input  logic             disp_D_rdy,
  input  logic [TAG_W-1:0] disp_D_tag,
  input  logic [31:0]      disp_D_value,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_id,
  input  logic [31:0]      cdb_value,
  input  logic             flush,
  output logic             mem_MemRead_M,
  output logic             mem_MemWrite_M,
  output logic             mem_valid_M,
  output logic [TAG_W-1:0] mem_id_M,
  output logic [31:0]      mem_srcA_M,
  output logic [31:0]      mem_scrB_M,
  output logic [31:0]      mem_store_data_M
);

  import mem_pkg::*;

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  mem_entry_t       ent_q [DEPTH];
  mem_entry_t       ent_d [DEPTH];
  mem_opnd_t        snoop_a [DEPTH];
  mem_opnd_t        snoop_b [DEPTH];
  mem_opnd_t        snoop_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             out_valid_q, out_valid_d;
  logic             out_read_q, out_read_d;
  logic             out_write_q, out_write_d;
  logic [TAG_W-1:0] out_id_q, out_id_d;
  logic [31:0]      out_srca_q, out_srca_d;
  logic [31:0]      out_srcb_q, out_srcb_d;
  logic [31:0]      out_sdata_q, out_sdata_d;

  mem_entry_t disp_ent;
  logic [2:0] disp_hit;
  logic       disp_block;
  logic       do_disp, do_issue;
  mem_entry_t head_ent;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    mem_rs_operand u_opnd_a (
      .valid_i(ent_q[i].valid), .opnd_i(ent_q[i].a), .cdb_valid_i(cdb_valid),
      .cdb_id_i(cdb_id), .cdb_value_i(cdb_value), .opnd_o(snoop_a[i])
    );
    mem_rs_operand u_opnd_b (
      .valid_i(ent_q[i].valid), .opnd_i(ent_q[i].b), .cdb_valid_i(cdb_valid),
      .cdb_id_i(cdb_id), .cdb_value_i(cdb_value), .opnd_o(snoop_b[i])
    );
    mem_rs_operand u_opnd_d (
      .valid_i(ent_q[i].valid), .opnd_i(ent_q[i].d), .cdb_valid_i(cdb_valid),
      .cdb_id_i(cdb_id), .cdb_value_i(cdb_value), .opnd_o(snoop_d[i])
    );
  end

  // Loads never read D, so it is marked present regardless of disp_D_rdy.
  always_comb begin
    disp_ent           = '0;
    disp_ent.valid     = 1'b1;
    disp_ent.mem_read  = disp_MemRead;
    disp_ent.mem_write = disp_MemWrite;
    disp_ent.id        = disp_id;
    disp_ent.a         = '{rdy: disp_A_rdy, tag: disp_A_tag, value: disp_A_value};
    disp_ent.b         = '{rdy: disp_B_rdy, tag: disp_B_tag, value: disp_B_value};
    disp_ent.d         = '{rdy: disp_D_rdy | ~disp_MemWrite, tag: disp_D_tag,
                           value: disp_D_value};
    disp_hit[0] = cdb_hit(disp_ent.a.rdy, disp_ent.a.tag, cdb_valid, cdb_id);
    disp_hit[1] = cdb_hit(disp_ent.b.rdy, disp_ent.b.tag, cdb_valid, cdb_id);
    disp_hit[2] = cdb_hit(disp_ent.d.rdy, disp_ent.d.tag, cdb_valid, cdb_id);
`ifdef MEM_RS_CDB_BYPASS_EN
    if (disp_hit[0]) begin disp_ent.a.rdy = 1'b1; disp_ent.a.value = cdb_value; end
    if (disp_hit[1]) begin disp_ent.b.rdy = 1'b1; disp_ent.b.value = cdb_value; end
    if (disp_hit[2]) begin disp_ent.d.rdy = 1'b1; disp_ent.d.value = cdb_value; end
`endif
  end

`ifdef MEM_RS_CDB_BYPASS_EN
  assign disp_block = 1'b0;
`else
  assign disp_block = |disp_hit;
`endif

  // Handshake: an entry is accepted on the edge where disp_valid && disp_ready;
  // disp_ready depends only on occupancy, flush and the CDB race, never on issue.
  assign disp_ready = (count_q != FULL_CNT) & ~flush & ~disp_block;
  assign do_disp    = disp_valid & disp_ready;
  assign head_ent   = ent_q[head_q];
  assign do_issue   = head_ent.valid & head_ent.a.rdy & head_ent.b.rdy &
                      head_ent.d.rdy & ~flush;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i]   = ent_q[i];
      ent_d[i].a = snoop_a[i];
      ent_d[i].b = snoop_b[i];
      ent_d[i].d = snoop_d[i];
    end
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    out_valid_d = 1'b0;
    out_read_d  = out_read_q;
    out_write_d = out_write_q;
    out_id_d    = out_id_q;
    out_srca_d  = out_srca_q;
    out_srcb_d  = out_srcb_q;
    out_sdata_d = out_sdata_q;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) ent_d[i].valid = 1'b0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_issue) begin
        ent_d[head_q].valid = 1'b0;
        head_d      = head_q + 1'b1;
        out_valid_d = 1'b1;
        out_read_d  = head_ent.mem_read;
        out_write_d = head_ent.mem_write;
        out_id_d    = head_ent.id;
        out_srca_d  = head_ent.a.value;
        out_srcb_d  = head_ent.b.value;
        out_sdata_d = head_ent.d.value;
      end
      if (do_disp) begin
        ent_d[tail_q] = disp_ent;
        tail_d        = tail_q + 1'b1;
      end
      if (do_disp && !do_issue)      count_d = count_q + 1'b1;
      else if (!do_disp && do_issue) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_read_q  <= 1'b0;
      out_write_q <= 1'b0;
      out_id_q    <= '0;
      out_srca_q  <= '0;
      out_srcb_q  <= '0;
      out_sdata_q <= '0;
    end else begin
      ent_q       <= ent_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_read_q  <= out_read_d;
      out_write_q <= out_write_d;
      out_id_q    <= out_id_d;
      out_srca_q  <= out_srca_d;
      out_srcb_q  <= out_srcb_d;
      out_sdata_q <= out_sdata_d;
    end
  end

  assign mem_valid_M      = out_valid_q;
  assign mem_MemRead_M    = out_read_q;
  assign mem_MemWrite_M   = out_write_q;
  assign mem_id_M         = out_id_q;
  assign mem_srcA_M       = out_srca_q;
  assign mem_scrB_M       = out_srcb_q;
  assign mem_store_data_M = out_sdata_q;

endmodule

// File: tb/tb_mem_rs.sv
// Directed bench for mem_rs: a queue-level model predicts disp_ready and the
// issue outputs every cycle; literal checks pin the model on key scenarios.
module tb_mem_rs;

  localparam int DEPTH = 4;
`ifdef MEM_RS_CDB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        disp_valid, disp_MemRead, disp_MemWrite;
  logic [2:0]  disp_id;
  logic        disp_ready;
  logic        disp_A_rdy, disp_B_rdy, disp_D_rdy;
  logic [2:0]  disp_A_tag, disp_B_tag, disp_D_tag;
  logic [31:0] disp_A_value, disp_B_value, disp_D_value;
  logic        cdb_valid;
  logic [2:0]  cdb_id;
  logic [31:0] cdb_value;
  logic        flush;
  logic        mem_MemRead_M, mem_MemWrite_M, mem_valid_M;
  logic [2:0]  mem_id_M;
  logic [31:0] mem_srcA_M, mem_scrB_M, mem_store_data_M;

  always #5 clk = ~clk;

  mem_rs #(.DEPTH(DEPTH), .TAG_W(3)) dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_MemRead(disp_MemRead),
    .disp_MemWrite(disp_MemWrite), .disp_id(disp_id), .disp_ready(disp_ready),
    .disp_A_rdy(disp_A_rdy), .disp_A_tag(disp_A_tag), .disp_A_value(disp_A_value),
    .disp_B_rdy(disp_B_rdy), .disp_B_tag(disp_B_tag), .disp_B_value(disp_B_value),
    .disp_D_rdy(disp_D_rdy), .disp_D_tag(disp_D_tag), .disp_D_value(disp_D_value),
    .cdb_valid(cdb_valid), .cdb_id(cdb_id), .cdb_value(cdb_value), .flush(flush),
    .mem_MemRead_M(mem_MemRead_M), .mem_MemWrite_M(mem_MemWrite_M),
    .mem_valid_M(mem_valid_M), .mem_id_M(mem_id_M), .mem_srcA_M(mem_srcA_M),
    .mem_scrB_M(mem_scrB_M), .mem_store_data_M(mem_store_data_M)
  );

  // Operand index 0=A, 1=B, 2=D.
  typedef struct packed {
    logic            rd;
    logic            wr;
    logic [2:0]      id;
    logic [2:0]      rdy;
    logic [2:0][2:0] tag;
    logic [2:0][31:0] val;
  } m_ent_t;

  m_ent_t      exp_q[$];
  logic        ev, er, ew;
  logic [2:0]  eid;
  logic [31:0] ea, eb, ed;
  int          n_pass = 0;
  int          n_chk  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic chk_out(input string tag);
    chk({tag, ".mem_valid_M"},      {31'd0, mem_valid_M},    {31'd0, ev});
    chk({tag, ".mem_MemRead_M"},    {31'd0, mem_MemRead_M},  {31'd0, er});
    chk({tag, ".mem_MemWrite_M"},   {31'd0, mem_MemWrite_M}, {31'd0, ew});
    chk({tag, ".mem_id_M"},         {29'd0, mem_id_M},       {29'd0, eid});
    chk({tag, ".mem_srcA_M"},       mem_srcA_M,              ea);
    chk({tag, ".mem_scrB_M"},       mem_scrB_M,              eb);
    chk({tag, ".mem_store_data_M"}, mem_store_data_M,        ed);
  endtask

  task automatic model_reset();
    exp_q.delete();
    ev = 1'b0; er = 1'b0; ew = 1'b0; eid = '0;
    ea = '0; eb = '0; ed = '0;
  endtask

  task automatic idle();
    disp_valid = 1'b0; disp_MemRead = 1'b0; disp_MemWrite = 1'b0; disp_id = '0;
    disp_A_rdy = 1'b1; disp_A_tag = '0; disp_A_value = '0;
    disp_B_rdy = 1'b1; disp_B_tag = '0; disp_B_value = '0;
    disp_D_rdy = 1'b1; disp_D_tag = '0; disp_D_value = '0;
    cdb_valid = 1'b0; cdb_id = '0; cdb_value = '0;
    flush = 1'b0;
  endtask

  task automatic disp(input logic wr, input logic [2:0] id,
                      input logic ar, input logic [2:0] at, input logic [31:0] av,
                      input logic br, input logic [2:0] bt, input logic [31:0] bv,
                      input logic dr, input logic [2:0] dt, input logic [31:0] dv);
    idle();
    disp_valid = 1'b1; disp_MemRead = ~wr; disp_MemWrite = wr; disp_id = id;
    disp_A_rdy = ar; disp_A_tag = at; disp_A_value = av;
    disp_B_rdy = br; disp_B_tag = bt; disp_B_value = bv;
    disp_D_rdy = dr; disp_D_tag = dt; disp_D_value = dv;
  endtask

  task automatic cdb(input logic [2:0] id, input logic [31:0] val);
    cdb_valid = 1'b1; cdb_id = id; cdb_value = val;
  endtask

  // One clock: predict disp_ready and the post-edge outputs, then compare.
  task automatic cycle();
    m_ent_t ne, e;
    logic   hz, rdy_exp;
    #2;
    ne.rd = disp_MemRead; ne.wr = disp_MemWrite; ne.id = disp_id;
    ne.rdy = {disp_D_rdy | ~disp_MemWrite, disp_B_rdy, disp_A_rdy};
    ne.tag[0] = disp_A_tag; ne.tag[1] = disp_B_tag; ne.tag[2] = disp_D_tag;
    ne.val[0] = disp_A_value; ne.val[1] = disp_B_value; ne.val[2] = disp_D_value;
    hz = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (cdb_valid && !ne.rdy[k] && ne.tag[k] == cdb_id) begin
        hz = 1'b1;
        if (BYPASS) begin ne.rdy[k] = 1'b1; ne.val[k] = cdb_value; end
      end
    end
    rdy_exp = (exp_q.size() < DEPTH) && !flush && (BYPASS || !hz);
    chk("cyc.disp_ready", {31'd0, disp_ready}, {31'd0, rdy_exp});
    if (flush) begin
      exp_q.delete();
      ev = 1'b0;
    end else begin
      if (exp_q.size() > 0 && (&exp_q[0].rdy)) begin
        e = exp_q.pop_front();
        ev = 1'b1; er = e.rd; ew = e.wr; eid = e.id;
        ea = e.val[0]; eb = e.val[1]; ed = e.val[2];
      end else begin
        ev = 1'b0;
      end
      for (int i = 0; i < exp_q.size(); i++) begin
        e = exp_q[i];
        for (int k = 0; k < 3; k++)
          if (cdb_valid && !e.rdy[k] && e.tag[k] == cdb_id) begin
            e.rdy[k] = 1'b1; e.val[k] = cdb_value;
          end
        exp_q[i] = e;
      end
      if (disp_valid && rdy_exp) exp_q.push_back(ne);
    end
    @(posedge clk);
    #1;
    chk_out("cyc");
  endtask

  initial begin
    rst = 1'b1;
    idle();
    model_reset();
    #1 rst = 1'b0;
    #2;
    chk_out("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    // Load, both address operands ready: visible after two edges for one cycle.
    disp(1'b0, 3'd2, 1'b1, 3'd0, 32'h100, 1'b1, 3'd0, 32'h4, 1'b0, 3'd0, 32'h0);
    cycle();
    idle(); cycle();
    chk("ld.valid", {31'd0, mem_valid_M}, 32'd1);
    chk("ld.read", {31'd0, mem_MemRead_M}, 32'd1);
    chk("ld.id", {29'd0, mem_id_M}, 32'd2);
    chk("ld.srcA", mem_srcA_M, 32'h100);
    chk("ld.scrB", mem_scrB_M, 32'h4);
    idle(); cycle();
    chk("ld.one_cycle", {31'd0, mem_valid_M}, 32'd0);
    chk("ld.hold_id", {29'd0, mem_id_M}, 32'd2);

    // Store waiting on tag 3 for its data.
    disp(1'b1, 3'd5, 1'b1, 3'd0, 32'h200, 1'b1, 3'd0, 32'h8, 1'b0, 3'd3, 32'h0);
    cycle();
    idle(); cdb(3'd3, 32'hDEADBEEF); cycle();
    chk("st.not_same_cycle", {31'd0, mem_valid_M}, 32'd0);
    idle(); cycle();
    chk("st.valid", {31'd0, mem_valid_M}, 32'd1);
    chk("st.write", {31'd0, mem_MemWrite_M}, 32'd1);
    chk("st.data", mem_store_data_M, 32'hDEADBEEF);
    idle(); cycle();

    // Blocked head, ready second entry; dispatch again while the head issues.
    disp(1'b0, 3'd6, 1'b0, 3'd1, 32'h0, 1'b1, 3'd0, 32'h4, 1'b0, 3'd0, 32'h0);
    cycle();
    disp(1'b0, 3'd7, 1'b1, 3'd0, 32'h700, 1'b1, 3'd0, 32'h70, 1'b0, 3'd0, 32'h0);
    cycle();
    idle(); cycle();
    idle(); cycle();
    chk("ooo.blocked", {31'd0, mem_valid_M}, 32'd0);
    idle(); cdb(3'd1, 32'h300); cycle();
    disp(1'b0, 3'd0, 1'b1, 3'd0, 32'h800, 1'b1, 3'd0, 32'h80, 1'b0, 3'd0, 32'h0);
    cycle();
    chk("ooo.first_id", {29'd0, mem_id_M}, 32'd6);
    chk("ooo.first_srcA", mem_srcA_M, 32'h300);
    idle(); cycle();
    chk("ooo.second_id", {29'd0, mem_id_M}, 32'd7);
    idle(); cycle();
    chk("ooo.third_id", {29'd0, mem_id_M}, 32'd0);
    chk("ooo.third_srcA", mem_srcA_M, 32'h800);
    idle(); cycle();

    // Fill the queue, try to overfill, then drain through a wrap.
    for (int k = 0; k < DEPTH; k++) begin
      disp(1'b1, 3'(k), 1'b1, 3'd0, 32'h10 * k, 1'b1, 3'd0, 32'(k),
           1'b0, 3'(k + 1), 32'h0);
      cycle();
    end
    idle(); #1;
    chk("full.disp_ready", {31'd0, disp_ready}, 32'd0);
    disp(1'b0, 3'd4, 1'b1, 3'd0, 32'h999, 1'b1, 3'd0, 32'h9, 1'b0, 3'd0, 32'h0);
    cycle();
    idle(); cdb(3'd1, 32'hD1); cycle();
    idle(); cdb(3'd2, 32'hD2); cycle();
    chk("wrap.first_id", {29'd0, mem_id_M}, 32'd0);
    chk("wrap.first_data", mem_store_data_M, 32'hD1);
    idle(); cdb(3'd3, 32'hD3); cycle();
    idle(); cdb(3'd4, 32'hD4); cycle();
    disp(1'b0, 3'd4, 1'b1, 3'd0, 32'h555, 1'b1, 3'd0, 32'h5, 1'b0, 3'd0, 32'h0);
    cycle();
    chk("wrap.last_id", {29'd0, mem_id_M}, 32'd3);
    for (int k = 0; k < 3; k++) begin idle(); cycle(); end

    // Flush with three waiting entries; a dispatch in the flush cycle is ignored.
    for (int k = 1; k <= 3; k++) begin
      disp(1'b0, 3'(k), 1'b0, 3'd2, 32'h0, 1'b1, 3'd0, 32'h1, 1'b0, 3'd0, 32'h0);
      cycle();
    end
    disp(1'b0, 3'd4, 1'b1, 3'd0, 32'h44, 1'b1, 3'd0, 32'h4, 1'b0, 3'd0, 32'h0);
    flush = 1'b1;
    cycle();
    chk("flush.valid", {31'd0, mem_valid_M}, 32'd0);
    idle(); #1;
    chk("flush.empty_ready", {31'd0, disp_ready}, 32'd1);
    cdb(3'd2, 32'h222); cycle();
    idle(); cycle();
    idle(); cycle();
    chk("flush.no_stale", {31'd0, mem_valid_M}, 32'd0);

    // Dispatch racing a CDB broadcast for one of its own operands.
    disp(1'b0, 3'd3, 1'b0, 3'd4, 32'h0, 1'b1, 3'd0, 32'h40, 1'b0, 3'd0, 32'h0);
    cdb(3'd4, 32'h444);
    #1;
`ifdef MEM_RS_CDB_BYPASS_EN
    chk("byp.disp_ready", {31'd0, disp_ready}, 32'd1);
`else
    chk("byp.disp_ready", {31'd0, disp_ready}, 32'd0);
`endif
    cycle();
    idle(); cycle();
`ifdef MEM_RS_CDB_BYPASS_EN
    chk("byp.issue", {31'd0, mem_valid_M}, 32'd1);
    chk("byp.srcA", mem_srcA_M, 32'h444);
`else
    chk("byp.no_issue", {31'd0, mem_valid_M}, 32'd0);
`endif
    idle(); cycle();

    // Reset in the middle of operation drops queued work.
    for (int k = 1; k <= 2; k++) begin
      disp(1'b0, 3'(k), 1'b0, 3'd5, 32'h0, 1'b1, 3'd0, 32'h2, 1'b0, 3'd0, 32'h0);
      cycle();
    end
    idle();
    rst = 1'b0;
    model_reset();
    #1;
    chk_out("midrst");
    @(posedge clk); #1;
    rst = 1'b1;
    cdb(3'd5, 32'h555); cycle();
    idle(); cycle();
    idle(); cycle();
    chk("midrst.no_issue", {31'd0, mem_valid_M}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_rs.md
MEM_RS -- requirements
Module: mem_rs

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queue entries (power of two, 2..8).
REQ-002 SHALL have parameter TAG_W, default 3, width of producer ids and tags.
REQ-003 SHALL have ports clk in 1 clock, and rst in 1 reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have dispatch inputs disp_valid 1, disp_MemRead 1, disp_MemWrite 1, disp_id TAG_W, and output disp_ready 1.
REQ-005 SHALL have per-operand dispatch inputs for X in {A,B,D}: disp_X_rdy 1 (value present), disp_X_tag TAG_W (producer id), disp_X_value 32.
REQ-006 SHALL have CDB snoop inputs cdb_valid 1, cdb_id TAG_W, cdb_value 32.
REQ-007 SHALL have input flush 1, which discards all queued work.
REQ-008 SHALL have issue outputs mem_MemRead_M 1, mem_MemWrite_M 1, mem_valid_M 1, mem_id_M TAG_W, mem_srcA_M 32, mem_scrB_M 32, mem_store_data_M 32, all registered, feeding the memory pipe.

Function
REQ-009 SHALL hold entries in a circular in-order queue, with head/tail pointers wrapping modulo DEPTH and a count 0..DEPTH.
REQ-010 SHALL drive disp_ready = (count < DEPTH) & ~flush, with no same-cycle credit from a simultaneous issue.
REQ-011 SHALL write an entry at tail on the clock edge where disp_valid & disp_ready.
REQ-012 SHALL force operand D ready at dispatch for loads (disp_MemWrite=0).
REQ-013 SHALL, each cycle while cdb_valid, load cdb_value into every valid entry operand that is not ready and whose tag equals cdb_id, and mark it ready.
REQ-014 SHALL consider only the head entry for issue, with no out-of-order memory access.
REQ-015 SHALL issue the head when it is valid with A, B and D ready and flush=0; the head is popped at the edge and the outputs carry it for exactly one cycle after that edge.
REQ-016 SHALL drive mem_valid_M=1 only in the cycle following an issue; otherwise mem_valid_M=0 and the other outputs hold their last values.
REQ-017 SHALL give a minimum latency of one cycle from dispatch to issue: an entry dispatched with all operands ready at edge t appears on the outputs after edge t+1.
REQ-018 SHALL, when dispatch and issue occur in the same cycle, perform both, leaving count unchanged.
REQ-019 SHALL, on a CDB match for the head in cycle t, make the head eligible at edge t+1, never in the same cycle.
REQ-020 SHALL, on flush, clear all valid bits, count and pointers, deassert mem_valid_M at the next edge, and ignore dispatch and issue in that cycle.
REQ-021 SHALL perform no issue when empty and no dispatch when full; DEPTH consecutive dispatches followed by a wrap SHALL preserve order.

Reset
REQ-022 SHALL, while rst=0, asynchronously clear count, pointers and all entry valid bits, and drive mem_valid_M, mem_MemRead_M and mem_MemWrite_M to 0, mem_id_M to 0, and all 32-bit outputs to 0.
REQ-023 SHALL, on reset asserted mid-operation, lose all queued entries with no issue after release until a new dispatch occurs.

Configuration
REQ-024 SHALL provide macro MEM_RS_CDB_BYPASS_EN: when defined, a dispatched operand that is not ready and whose tag equals cdb_id with cdb_valid in the dispatch cycle is captured as ready with cdb_value.
REQ-025 SHALL, without MEM_RS_CDB_BYPASS_EN, deassert disp_ready in any cycle where cdb_valid and a not-ready dispatch operand tag equals cdb_id.

Structure
REQ-026 SHALL place TAG_W, DATA_W=32 and the entry typedef (valid, MemRead, MemWrite, id, 3x{rdy, tag, value}) in shared package mem_pkg.
REQ-027 SHALL implement per-operand tag compare and capture in one sub-module mem_rs_operand, instantiated 3 x DEPTH.

Verification
REQ-028 SHALL cover: dispatch of a load with id=2, A=0x100 ready and B=0x4 ready -> after 2 edges mem_valid_M=1, MemRead=1, id=2, srcA=0x100, scrB=0x4, for one cycle.
REQ-029 SHALL cover: dispatch of a store id=5 with D waiting on tag 3, then cdb_valid, id=3, value=0xDEADBEEF -> the next cycle issues with store_data=0xDEADBEEF and MemWrite=1.
REQ-030 SHALL cover: head waiting on tag 1 and second entry fully ready -> no issue until CDB id=1 arrives, then both issue in order on consecutive cycles.
REQ-031 SHALL cover: 4 dispatches with DEPTH=4 and no CDB -> disp_ready=0; 4 CDB completions -> 4 in-order issues, pointers wrap, and a fifth dispatch is accepted.
REQ-032 SHALL cover: 3 entries queued and flush pulsed -> count=0, mem_valid_M=0, and no issue from stale entries after later CDB traffic.
REQ-033 SHALL cover: dispatch with A tag=4 not ready while cdb_valid and cdb_id=4 -> with MEM_RS_CDB_BYPASS_EN the entry is captured; without it disp_ready=0 for that cycle.
